// File: rtl/seq_detector_param_if.sv
// Serial bit-stream bundle for seq_detector_param: the bit source drives the master side,
// and the detector sits on the slave side.
interface seq_detector_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             x;
    logic             x_valid;
    logic             load;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic             z;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output x, x_valid, load, pattern, overlap,
        input  z, match_cnt
    );

    modport slave (
        input  x, x_valid, load, pattern, overlap,
        output z, match_cnt
    );
endinterface

// File: rtl/seq_detector_param.sv
// Moore detector for a runtime-loadable PAT_W-bit pattern, in overlap or non-overlap mode.
// Define SEQ_DET_MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt reads 0.
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1010)
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_param_if.slave  bus
);
    localparam int             FW   = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FULL = FW'(PAT_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_ARMED,
        S_DET
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [PAT_W-1:0] r_pat,   w_pat_nxt;
    logic             r_ovl,   w_ovl_nxt;
    logic [PAT_W-1:0] r_hist,  w_hist_nxt;
    logic [FW-1:0]    r_fill,  w_fill_nxt;

    logic [PAT_W-1:0] w_nh;
    logic [FW-1:0]    w_nf;
    logic             w_match;

    assign w_nh    = {r_hist[PAT_W-2:0], bus.x};
    assign w_nf    = (r_fill == FULL) ? FULL : r_fill + FW'(1);
    assign w_match = (w_nf == FULL) && (w_nh == r_pat);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pat   <= RST_PAT;
            r_ovl   <= 1'b1;
            r_hist  <= '0;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_ovl   <= w_ovl_nxt;
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

    // NOTE: every output gets a hold default first, so no path through this block can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_ovl_nxt   = r_ovl;
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;

        if (bus.load) begin
            w_pat_nxt   = bus.pattern;
            w_ovl_nxt   = bus.overlap;
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
            w_state_nxt = S_IDLE;
        end else if (bus.x_valid) begin
            if (w_match) begin
                w_state_nxt = S_DET;
                // Non-overlap mode drops the matched bits so none of them start the next match.
                w_hist_nxt  = r_ovl ? w_nh : '0;
                w_fill_nxt  = r_ovl ? FULL : '0;
            end else begin
                w_hist_nxt  = w_nh;
                w_fill_nxt  = w_nf;
                w_state_nxt = (w_nf == FULL) ? S_ARMED : S_FILL;
            end
        end else if (r_state == S_DET) begin
            if (r_fill == '0) begin
                w_state_nxt = S_IDLE;
            end else if (r_fill == FULL) begin
                w_state_nxt = S_ARMED;
            end else begin
                w_state_nxt = S_FILL;
            end
        end
    end

    assign bus.z = (r_state == S_DET);

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.load) begin
            w_cnt_nxt = '0;
        end else if (bus.x_valid && w_match && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign bus.match_cnt = r_cnt;
`else
    assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: defaults, non-overlap, bubbles, load/reset mid-stream,
// and back-to-back matches with counter saturation on a second CNT_W=2 instance.
module tb_seq_detector_param;
`ifdef SEQ_DET_MATCH_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) bus  ();
    seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) bus2 ();

    assign bus2.x       = bus.x;
    assign bus2.x_valid = bus.x_valid;
    assign bus2.load    = bus.load;
    assign bus2.pattern = bus.pattern;
    assign bus2.overlap = bus.overlap;

    seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b, input logic v);
        @(negedge clk);
        bus.x       = b;
        bus.x_valid = v;
        bus.load    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // x is driven valid during the load cycle to confirm it is ignored.
    task automatic do_load(input logic [3:0] p, input logic o);
        @(negedge clk);
        bus.load    = 1'b1;
        bus.pattern = p;
        bus.overlap = o;
        bus.x       = 1'b1;
        bus.x_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.load    = 1'b0;
        bus.x_valid = 1'b0;
        check("load_z",   32'(bus.z), 32'(0));
        check("load_cnt", 32'(bus.match_cnt), 32'(0));
    endtask

    // Sends n bits (first bit is bits[n-1]) and checks z after each against ez.
    task automatic send(input logic [14:0] bits, input logic [14:0] ez, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(bits[n-1-i], 1'b1);
            check($sformatf("%s_b%0d_z", tag, i + 1), 32'(bus.z), 32'(ez[n-1-i]));
        end
    endtask

    task automatic bubble(input string tag);
        step(1'b1, 1'b0);
        check(tag, 32'(bus.z), 32'(0));
    endtask

    localparam logic [14:0] STREAM = 15'b110101011101010;
    localparam logic [14:0] EZ_OVL = 15'b000010100000101;
    localparam logic [14:0] EZ_NOV = 15'b000010000000100;

    initial begin
        rst         = 1'b1;
        bus.x       = 1'b0;
        bus.x_valid = 1'b0;
        bus.load    = 1'b0;
        bus.pattern = 4'b0000;
        bus.overlap = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_z",    32'(bus.z), 32'(0));
        check("rst_cnt",  32'(bus.match_cnt), 32'(0));
        check("rst_z2",   32'(bus2.z), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Reset defaults: pattern 1010, overlap mode.
        send(STREAM, EZ_OVL, 15, "dflt");
        check("dflt_cnt", 32'(bus.match_cnt), 32'(4 * CNT_EN));

        // Non-overlap mode.
        do_load(4'b1010, 1'b0);
        send(STREAM, EZ_NOV, 15, "nov");
        check("nov_cnt", 32'(bus.match_cnt), 32'(2 * CNT_EN));

        // Bubbles between bits 3 and 4, plus one right after the first match.
        do_load(4'b1010, 1'b1);
        send(15'b110, 15'b000, 3, "bub_a");
        bubble("bub_gap1_z");
        bubble("bub_gap2_z");
        bubble("bub_gap3_z");
        send(15'b10, 15'b01, 2, "bub_b");
        bubble("bub_det_exit_z");
        send(15'b1011101010, 15'b0100000101, 10, "bub_c");
        check("bub_cnt", 32'(bus.match_cnt), 32'(4 * CNT_EN));

        // Load mid-stream: partial 101 under 1010 must not survive the switch to 0110.
        do_load(4'b1010, 1'b1);
        send(15'b101, 15'b000, 3, "ld_pre");
        do_load(4'b0110, 1'b1);
        send(15'b0110, 15'b0001, 4, "ld_post");
        check("ld_cnt", 32'(bus.match_cnt), 32'(CNT_EN));

        // Reset while z is high clears z and the counter without waiting for a clock.
        do_load(4'b1010, 1'b1);
        send(15'b1010, 15'b0001, 4, "rs_a");
        @(negedge clk);
        bus.x_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rs_async_z",   32'(bus.z), 32'(0));
        check("rs_async_cnt", 32'(bus.match_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Reset after 101: a lone following 0 must not complete 1010.
        send(15'b101, 15'b000, 3, "rs_b");
        @(negedge clk);
        bus.x_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rs_b_cnt", 32'(bus.match_cnt), 32'(0));
        send(15'b0, 15'b0, 1, "rs_lone0");
        send(15'b1010, 15'b0001, 4, "rs_c");

        // Back-to-back matches on all-ones; CNT_W=2 instance saturates at 3.
        do_load(4'b1111, 1'b1);
        check("sat_load_cnt2", 32'(bus2.match_cnt), 32'(0));
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1);
            check($sformatf("sat_b%0d_z", i + 1),  32'(bus.z),  32'(i >= 3));
            check($sformatf("sat_b%0d_z2", i + 1), 32'(bus2.z), 32'(i >= 3));
        end
        check("sat_cnt2", 32'(bus2.match_cnt), 32'(3 * CNT_EN));
        check("sat_cnt",  32'(bus.match_cnt),  32'(4 * CNT_EN));
        step(1'b0, 1'b1);
        check("sat_end_z", 32'(bus.z), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Moore sequence detector for serial bit streams. It generalises the fixed 1010 detector to a runtime-loadable pattern of PAT_W bits, adds a selectable overlapping or non-overlapping mode, and adds a valid qualifier on the input bit. It sits after a serial bit source in the lab datapath and produces a registered one-cycle match pulse, plus an optional saturating match counter.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..16.
- CNT_W, 8: match counter width; legal range 1..32.
- RST_PAT, 4'b1010 (zero-extended/truncated to PAT_W): pattern value held after reset.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- x  in  1  serial data bit.
- x_valid  in  1  high when x holds a bit to consume this cycle.
- load  in  1  one-cycle strobe that captures pattern/overlap and clears progress.
- pattern  in  PAT_W  new pattern; MSB is the first bit received.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- z  out  1  Moore match output; high one cycle per match.
- match_cnt  out  CNT_W  saturating match count (see Configuration).

## Operation
- Internal registers:
  - pat_r (PAT_W): active pattern.
  - ovl_r: active mode.
  - hist (PAT_W): last received bits, newest in the LSB.
  - fill (0..PAT_W): number of valid bits in hist.
  - state.
- States:
  - IDLE: fill = 0.
  - FILL: 0 < fill < PAT_W.
  - ARMED: fill = PAT_W, no match.
  - DET: match registered.
- z = (state == DET) only. It is a pure Moore output with no combinational path from x.
- On a consumed bit (x_valid=1, load=0):
  - nh = {hist[PAT_W-2:0], x}; nf = min(fill+1, PAT_W).
  - Match condition: nf == PAT_W and nh == pat_r.
  - On match: state -> DET.
    - ovl_r=1: hist <= nh, fill <= PAT_W.
    - ovl_r=0: hist <= 0, fill <= 0, so the matched bits are not reused.
  - No match: hist <= nh, fill <= nf; state -> FILL or ARMED according to nf.
- With x_valid=0 and load=0:
  - hist and fill hold.
  - DET exits to the state implied by fill (IDLE if fill=0, ARMED if fill=PAT_W).
  - Other states hold.
- DET followed by another matching bit in the next cycle: re-enter DET, so z stays high for consecutive matches. This can only occur in overlap mode with a periodic pattern such as all-ones.
- Load (priority over x_valid):
  - pat_r <= pattern, ovl_r <= overlap, hist <= 0, fill <= 0, state <= IDLE, match_cnt <= 0.
  - x is ignored in the load cycle.
- Reset values:
  - z=0, match_cnt=0, state=IDLE, hist=0, fill=0.
  - pat_r=RST_PAT, ovl_r=1.
- Reset asserted mid-stream: all progress is discarded immediately. The first PAT_W bits after reset release can never be a partial continuation of pre-reset bits.

## Timing
- Latency: z rises on the clock edge that consumes the final pattern bit, so it is visible the cycle after that bit is presented.
- z width: exactly one clock per match unless the next bit also completes a match.
- The earliest first match is on the PAT_W-th consumed bit after reset or load.
- pattern and overlap are sampled only in load cycles; changes between loads have no effect.
- match_cnt updates on the same edge that z rises. It saturates at 2^CNT_W-1 and never wraps.

## Configuration
- SEQ_DET_MATCH_CNT_EN defined:
  - match_cnt counter is built and increments by 1 on each entry into DET.
  - It is cleared by rst and load, and saturates.
- SEQ_DET_MATCH_CNT_EN undefined:
  - No counter flops; match_cnt is tied to all zeros.
  - z behaviour is unchanged.

## Test plan
- Reset defaults:
  - Stimulus: PAT_W=4, overlap mode, x_valid=1 every cycle, stream 1,1,0,1,0,1,0,1,1,1,0,1,0,1,0.
  - Required: z pulses after bits 5, 7, 13 and 15; match_cnt=4.
- Non-overlap mode:
  - Stimulus: load pattern 4'b1010 with overlap=0, then the same stream.
  - Required: z pulses after bits 5 and 13 only; match_cnt=2.
- Bubbles:
  - Stimulus: the same overlap stream, with x_valid low for 3 cycles inserted between bits 3 and 4.
  - Required: z pulses at the same bit indices (5, 7, 13, 15); z stays low during the bubbles.
- Load and reset mid-stream:
  - Stimulus: send 1,0,1, then pulse load with pattern 4'b0110, then send 0,1,1,0.
  - Required: no z from the old pattern; z pulses after the second 0.
  - Stimulus: assert rst after bits 1,0,1.
  - Required: z=0 and match_cnt=0 immediately; a following 0 alone does not match.
- Back-to-back and saturation:
  - Stimulus: CNT_W=2, pattern 4'b1111, overlap mode, seven consecutive 1s.
  - Required: z high continuously from bit 4 to bit 7; match_cnt stops at 3.
- Macro off:
  - Stimulus: build without SEQ_DET_MATCH_CNT_EN and repeat the first scenario.
  - Required: identical z pulses; match_cnt stays 0 throughout.
